sync_edge_filter: RTL and testbench
===================================

# sync_edge_filter

Multi-channel asynchronous-input conditioner for the destination clock domain. Each channel has a parametrised synchroniser chain and a consecutive-cycle glitch filter. It also has a per-channel selectable edge detector producing one-cycle pulses, plus sticky event and overflow flags with write-1-to-clear. It sits at the boundary where slow or external control signals enter the `clk2` domain. It generalises the fixed 2/3-stage synchronise-and-detect block to CH channels, configurable depth and debounce.

## Interface
- `CH`, 4, number of independent channels (≥1)
- `SYNC_STAGES`, 2, synchroniser flops per channel (≥2)
- `FILT_CNT`, 4, consecutive disagreeing cycles required before the filtered level changes (≥1; 1 = no filtering)
- `clk2` input 1: destination clock; the only clock in the block
- `rstn` input 1: reset, asynchronous, active-low
- `sig_in` input CH: asynchronous inputs, one per channel
- `mode` input 2*CH: per-channel edge select; bits [2i+1:2i] for channel i; 00 off, 01 rising, 10 falling, 11 both
- `evt_clr` input CH: per-channel write-1-to-clear for `evt_flag` / `evt_ovf`, synchronous to `clk2`
- `level_out` output CH: filtered, synchronised level
- `pulse_out` output CH: one-cycle pulse on a selected edge of `level_out`
- `evt_flag` output CH: sticky, set by `pulse_out`
- `evt_ovf` output CH: sticky, event arrived while `evt_flag` was already set

## Operation
- All registers and outputs reset to 0: sync chains, filtered level, counters, `level_out`, `pulse_out`, `evt_flag` and `evt_ovf`.
- **Sync chain:** a channel's chain shifts in `sig_in[i]` every edge. Let `s` be its last stage.
- **Filter state:** each channel holds level register `f` (drives `level_out`) and counter `cnt`, width clog2(FILT_CNT+1).
  - `s == f`: `cnt` <= 0.
  - `s != f` and `cnt < FILT_CNT-1`: `cnt` <= `cnt` + 1.
  - `s != f` and `cnt == FILT_CNT-1`: `f` <= `s`, `cnt` <= 0. This is the update edge.
- **Glitch rejection:** any excursion of `s` lasting fewer than FILT_CNT consecutive cycles never reaches `f`. The counter restarts on every return to agreement.
- **Edge detect:** `mode` is sampled at the update edge.
  - `pulse_out[i]` is registered and is 1 for exactly the cycle after the update edge when the edge direction matches `mode`.
  - Rising means `f` 0→1; falling means `f` 1→0.
  - Mode 00 gives no pulse, but `level_out` still tracks.
- **Minimum pulse spacing:** pulses are at least FILT_CNT cycles apart per channel, so no back-to-back pulses when FILT_CNT>1.
- **Flags, per channel, evaluated each edge with p = next `pulse_out`:**
  - p=1 and `evt_flag`=1 and `evt_clr`=0: `evt_ovf` <= 1.
  - p=1: `evt_flag` <= 1. Set wins over simultaneous `evt_clr`; `evt_ovf` is then cleared by the clr.
  - p=0 and `evt_clr`=1: `evt_flag` <= 0, `evt_ovf` <= 0.
  - Otherwise both hold.
- **Independence:** channels are fully independent; no cross-channel state.
- **Reset release with input high:** `sig_in` high when reset is released yields a rising event after the normal latency, since `f` resets to 0. This is intended.
- **Reset mid-operation:** reset asserted mid-filter or mid-pulse clears everything immediately and asynchronously. No pulse is emitted on release unless the input re-qualifies.

## Timing
- **Reference edge:** E0 is the first `clk2` rising edge to capture a stable new `sig_in` value.
- **Chain latency:** `s` shows the value after edge E0+SYNC_STAGES-1.
- **Update edge:** E0+SYNC_STAGES+FILT_CNT-1.
  - `level_out` changes after this edge.
  - `pulse_out` is high for the cycle between that edge and the next.
  - `evt_flag` is set at the same edge as `pulse_out` rises.
- **Default latency:** defaults (2, 4) give an update edge of E0+5. With SYNC_STAGES=2, FILT_CNT=1 it is E0+2, matching the legacy 2-stage detector.
- **Clear latency:** `evt_clr` takes effect at the next edge, giving a single-cycle response.
- **Inputs:** no combinational path from any input to any output.

## Test plan
- **Reset values:** rstn=0 with `sig_in`=all 1 → all outputs 0. Release rstn with defaults and mode=11 → `level_out`=1 and a single `pulse_out` cycle after edge E0+5, then `evt_flag`=1.
- **Glitch filter:** FILT_CNT=4, channel 0 high for 3 `clk2` cycles → no `level_out` change, no pulse. High for 4 cycles → rising pulse at the update edge and again the falling pulse after it drops (mode=11).
- **Mode selection:** 4 channels driven with the same square wave, mode=00/01/10/11 → ch0 no pulses; ch1 rising only; ch2 falling only; ch3 both. `level_out` identical on all four.
- **Sticky flags:** two rising events without clear → `evt_flag`=1, `evt_ovf`=1. `evt_clr`=1 for one cycle → both 0 next cycle.
- **Simultaneous clear and event:** `evt_clr` asserted at the same edge as the pulse → `evt_flag`=1, `evt_ovf`=0. A further pulse without clear → `evt_ovf`=1.
- **Asynchronous reset:** rstn pulsed low mid-count, with `cnt`=2 of 4 → all outputs 0 immediately. After release with `sig_in` stable 0 → no pulse.

Source files
------------

// File: rtl/sync_edge_filter.sv
// sync_edge_filter
//   Multi-channel conditioner for asynchronous inputs entering the clk2 domain.
//   Each channel passes through a synchroniser chain, then a consecutive-cycle
//   glitch filter that produces a clean level. A selectable edge detector turns
//   level changes into one-cycle pulses, which set sticky event and overflow
//   flags that are cleared by writing 1 to evt_clr.
//
// Ports
//   clk2      : destination clock, the only clock in the block
//   rstn      : asynchronous active-low reset
//   sig_in    : asynchronous inputs, one per channel
//   mode      : per-channel edge select, bits [2i+1:2i]; 00 off, 01 rise, 10 fall, 11 both
//   evt_clr   : per-channel write-1-to-clear for evt_flag / evt_ovf
//   level_out : filtered, synchronised level
//   pulse_out : one-cycle pulse on a selected edge of level_out
//   evt_flag  : sticky, set by pulse_out
//   evt_ovf   : sticky, event arrived while evt_flag was already set
module sync_edge_filter #(
    parameter int unsigned CH          = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_CNT    = 4
) (
    input  logic            clk2,
    input  logic            rstn,
    input  logic [CH-1:0]   sig_in,
    input  logic [2*CH-1:0] mode,
    input  logic [CH-1:0]   evt_clr,
    output logic [CH-1:0]   level_out,
    output logic [CH-1:0]   pulse_out,
    output logic [CH-1:0]   evt_flag,
    output logic [CH-1:0]   evt_ovf
);

    localparam int unsigned CntW = $clog2(FILT_CNT + 1);
    localparam logic [CntW-1:0] CntMax = CntW'(FILT_CNT - 1);

    logic [CH-1:0][SYNC_STAGES-1:0] sync_q, sync_d;
    logic [CH-1:0][CntW-1:0]        cnt_q, cnt_d;
    logic [CH-1:0]                  sync_s;
    logic [CH-1:0]                  level_q, level_d;
    logic [CH-1:0]                  pulse_q, pulse_d;
    logic [CH-1:0]                  flag_q, flag_d;
    logic [CH-1:0]                  ovf_q, ovf_d;

    // Synchroniser chains; bit 0 captures the raw input.
    always_comb begin
        sync_d = sync_q;
        sync_s = '0;
        for (int i = 0; i < int'(CH); i++) begin
            sync_d[i] = {sync_q[i][SYNC_STAGES-2:0], sig_in[i]};
            sync_s[i] = sync_q[i][SYNC_STAGES-1];
        end
    end

    // Glitch filter and edge detect. The level only follows the synchronised
    // input after FILT_CNT consecutive disagreeing cycles; any agreement restarts
    // the count. mode is looked at only on the cycle the level actually flips.
    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        pulse_d = '0;
        for (int i = 0; i < int'(CH); i++) begin
            if (sync_s[i] == level_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CntMax) begin
                level_d[i] = sync_s[i];
                cnt_d[i]   = '0;
                pulse_d[i] = sync_s[i] ? mode[2*i] : mode[2*i+1];
            end else begin
                cnt_d[i] = cnt_q[i] + CntW'(1);
            end
        end
    end

    // Sticky flags. A new pulse always sets evt_flag even if evt_clr is high;
    // in that case the clear still wipes evt_ovf so software sees a fresh event.
    always_comb begin
        flag_d = flag_q;
        ovf_d  = ovf_q;
        for (int i = 0; i < int'(CH); i++) begin
            if (pulse_d[i]) begin
                flag_d[i] = 1'b1;
                if (evt_clr[i]) begin
                    ovf_d[i] = 1'b0;
                end else if (flag_q[i]) begin
                    ovf_d[i] = 1'b1;
                end
            end else if (evt_clr[i]) begin
                flag_d[i] = 1'b0;
                ovf_d[i]  = 1'b0;
            end
        end
    end

    always_ff @(posedge clk2 or negedge rstn) begin
        if (!rstn) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= '0;
            pulse_q <= '0;
            flag_q  <= '0;
            ovf_q   <= '0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
            pulse_q <= pulse_d;
            flag_q  <= flag_d;
            ovf_q   <= ovf_d;
        end
    end

    assign level_out = level_q;
    assign pulse_out = pulse_q;
    assign evt_flag  = flag_q;
    assign evt_ovf   = ovf_q;

endmodule

// File: tb/tb_sync_edge_filter.sv
// tb_sync_edge_filter
//   Self-checking bench for sync_edge_filter with default parameters. A
//   behavioural model keeps the raw input history, derives the synchronised
//   value as the sample taken SYNC_STAGES edges earlier, and flips the level
//   when the last FILT_CNT synchronised values all disagree with it.
module tb_sync_edge_filter;

    localparam int CH = 4;
    localparam int S  = 2;
    localparam int F  = 4;

    logic            clk2 = 1'b0;
    logic            rstn;
    logic [CH-1:0]   sig_in;
    logic [2*CH-1:0] mode;
    logic [CH-1:0]   evt_clr;
    logic [CH-1:0]   level_out;
    logic [CH-1:0]   pulse_out;
    logic [CH-1:0]   evt_flag;
    logic [CH-1:0]   evt_ovf;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model state
    logic [CH-1:0] m_level, m_pulse, m_flag, m_ovf;
    logic [CH-1:0] in_hist[$];
    logic [CH-1:0] s_hist[$];

    sync_edge_filter #(
        .CH          (CH),
        .SYNC_STAGES (S),
        .FILT_CNT    (F)
    ) dut (
        .clk2      (clk2),
        .rstn      (rstn),
        .sig_in    (sig_in),
        .mode      (mode),
        .evt_clr   (evt_clr),
        .level_out (level_out),
        .pulse_out (pulse_out),
        .evt_flag  (evt_flag),
        .evt_ovf   (evt_ovf)
    );

    always #5 clk2 = ~clk2;

    task automatic model_reset();
        m_level = '0;
        m_pulse = '0;
        m_flag  = '0;
        m_ovf   = '0;
        in_hist.delete();
        s_hist.delete();
    endtask

    // One clk2 edge of the reference model, using the inputs present at the edge.
    task automatic model_step();
        logic [CH-1:0] s_prev;
        logic [CH-1:0] new_pulse;
        int            n;
        bit            all_diff;
        in_hist.push_back(sig_in);
        n = in_hist.size();
        // Value visible at the end of the chain just before this edge.
        s_prev = (n - 1 - S >= 0) ? in_hist[n-1-S] : '0;
        if (in_hist.size() > S + 1) void'(in_hist.pop_front());
        s_hist.push_back(s_prev);
        if (s_hist.size() > F) void'(s_hist.pop_front());
        new_pulse = '0;
        for (int c = 0; c < CH; c++) begin
            if (s_hist.size() == F) begin
                all_diff = 1'b1;
                foreach (s_hist[k]) if (s_hist[k][c] == m_level[c]) all_diff = 1'b0;
                if (all_diff) begin
                    m_level[c]   = ~m_level[c];
                    new_pulse[c] = m_level[c] ? mode[2*c] : mode[2*c+1];
                end
            end
            if (new_pulse[c]) begin
                if (evt_clr[c]) m_ovf[c] = 1'b0;
                else if (m_flag[c]) m_ovf[c] = 1'b1;
                m_flag[c] = 1'b1;
            end else if (evt_clr[c]) begin
                m_flag[c] = 1'b0;
                m_ovf[c]  = 1'b0;
            end
        end
        m_pulse = new_pulse;
    endtask

    // Drive inputs on the falling edge, advance one rising edge, settle 1 time unit.
    task automatic cycle(input logic [CH-1:0] s, input logic [2*CH-1:0] m,
                         input logic [CH-1:0] c);
        @(negedge clk2);
        sig_in  = s;
        mode    = m;
        evt_clr = c;
        @(posedge clk2);
        if (rstn) model_step();
        #1;
    endtask

    task automatic test_reset();
        logic [CH-1:0] exp_p, exp_l;
        rstn    = 1'b0;
        sig_in  = '1;
        mode    = '1;
        evt_clr = '0;
        model_reset();
        repeat (3) @(posedge clk2);
        #1;
        n_checks++;
        if ({level_out, pulse_out, evt_flag, evt_ovf} !== 16'h0) begin
            n_fail++;
            $display("FAIL reset_values got=%h want=0000",
                     {level_out, pulse_out, evt_flag, evt_ovf});
        end
        rstn = 1'b1;
        for (int n = 0; n < 10; n++) begin
            cycle('1, '1, '0);
            exp_p = (n == S + F - 1) ? '1 : '0;
            exp_l = (n >= S + F - 1) ? '1 : '0;
            n_checks++;
            if ({level_out, pulse_out, evt_flag, evt_ovf} !== {exp_l, exp_p, exp_l, 4'h0}) begin
                n_fail++;
                $display("FAIL reset_release edge=E0+%0d got=%h want=%h", n,
                         {level_out, pulse_out, evt_flag, evt_ovf},
                         {exp_l, exp_p, exp_l, 4'h0});
            end
        end
    endtask

    task automatic test_glitch();
        int pc;
        for (int n = 0; n < 12; n++) cycle('0, '1, '1);
        for (int len = 3; len <= 4; len++) begin
            pc = 0;
            for (int n = 0; n < len + 16; n++) begin
                cycle((n < len) ? 4'b0001 : 4'b0000, '1, '0);
                pc += int'(pulse_out[0]);
                n_checks++;
                if ({level_out, pulse_out, evt_flag, evt_ovf} !==
                    {m_level, m_pulse, m_flag, m_ovf}) begin
                    n_fail++;
                    $display("FAIL glitch_len%0d cyc=%0d got=%h want=%h", len, n,
                             {level_out, pulse_out, evt_flag, evt_ovf},
                             {m_level, m_pulse, m_flag, m_ovf});
                end
            end
            n_checks++;
            if (pc != ((len == 3) ? 0 : 2)) begin
                n_fail++;
                $display("FAIL glitch_pulses_len%0d got=%0d want=%0d", len, pc,
                         (len == 3) ? 0 : 2);
            end
        end
    endtask

    task automatic test_modes();
        int pc[CH];
        int want[CH];
        logic [CH-1:0] s;
        want = '{0, 4, 4, 8};
        for (int c = 0; c < CH; c++) pc[c] = 0;
        for (int n = 0; n < 4 * 16 + 12; n++) begin
            s = (n < 64 && (n % 16) < 8) ? '1 : '0;
            cycle(s, 8'b11_10_01_00, '0);
            for (int c = 0; c < CH; c++) pc[c] += int'(pulse_out[c]);
            n_checks++;
            if ({level_out, pulse_out, evt_flag, evt_ovf} !==
                {m_level, m_pulse, m_flag, m_ovf} ||
                (level_out != '0 && level_out != '1)) begin
                n_fail++;
                $display("FAIL modes cyc=%0d got=%h want=%h", n,
                         {level_out, pulse_out, evt_flag, evt_ovf},
                         {m_level, m_pulse, m_flag, m_ovf});
            end
        end
        for (int c = 0; c < CH; c++) begin
            n_checks++;
            if (pc[c] != want[c]) begin
                n_fail++;
                $display("FAIL modes_pulses ch%0d got=%0d want=%0d", c, pc[c], want[c]);
            end
        end
    endtask

    task automatic test_sticky();
        cycle('0, 8'b01010101, '1);
        for (int n = 0; n < 24; n++) begin
            cycle(((n / 8) % 2 == 0) ? 4'b0001 : 4'b0000, 8'b01010101, '0);
            n_checks++;
            if ({level_out, pulse_out, evt_flag, evt_ovf} !==
                {m_level, m_pulse, m_flag, m_ovf}) begin
                n_fail++;
                $display("FAIL sticky cyc=%0d got=%h want=%h", n,
                         {level_out, pulse_out, evt_flag, evt_ovf},
                         {m_level, m_pulse, m_flag, m_ovf});
            end
        end
        n_checks++;
        if ({evt_flag[0], evt_ovf[0]} !== 2'b11) begin
            n_fail++;
            $display("FAIL sticky_two_events flag/ovf got=%b want=11", {evt_flag[0], evt_ovf[0]});
        end
        cycle(4'b0001, 8'b01010101, 4'b0001);
        n_checks++;
        if ({evt_flag[0], evt_ovf[0]} !== 2'b00) begin
            n_fail++;
            $display("FAIL sticky_clear flag/ovf got=%b want=00", {evt_flag[0], evt_ovf[0]});
        end
        for (int n = 0; n < 12; n++) cycle('0, 8'b01010101, '0);
    endtask

    task automatic test_simul_clear();
        for (int n = 0; n < 16; n++) cycle((n < 8) ? 4'b0001 : 4'b0000, '1, '0);
        n_checks++;
        if ({evt_flag[0], evt_ovf[0]} !== 2'b11) begin
            n_fail++;
            $display("FAIL simul_precond flag/ovf got=%b want=11", {evt_flag[0], evt_ovf[0]});
        end
        for (int n = 0; n < S + F; n++) cycle(4'b0001, '1, (n == S + F - 1) ? 4'b0001 : 4'b0000);
        n_checks++;
        if ({pulse_out[0], evt_flag[0], evt_ovf[0]} !== 3'b110) begin
            n_fail++;
            $display("FAIL simul_clear pulse/flag/ovf got=%b want=110",
                     {pulse_out[0], evt_flag[0], evt_ovf[0]});
        end
        for (int n = 0; n < 12; n++) cycle('0, '1, '0);
        n_checks++;
        if ({evt_flag[0], evt_ovf[0]} !== 2'b11 ||
            {m_flag[0], m_ovf[0]} !== {evt_flag[0], evt_ovf[0]}) begin
            n_fail++;
            $display("FAIL simul_next_event flag/ovf got=%b want=11", {evt_flag[0], evt_ovf[0]});
        end
    endtask

    task automatic test_async_reset();
        int pc;
        for (int n = 0; n < 10; n++) cycle('1, '1, '0);
        for (int n = 0; n < S + 2; n++) cycle('0, '1, '0);
        n_checks++;
        if (level_out !== '1) begin
            n_fail++;
            $display("FAIL areset_precond level got=%b want=1111", level_out);
        end
        #2;
        rstn = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if ({level_out, pulse_out, evt_flag, evt_ovf} !== 16'h0) begin
            n_fail++;
            $display("FAIL areset_immediate got=%h want=0000",
                     {level_out, pulse_out, evt_flag, evt_ovf});
        end
        @(posedge clk2);
        #1;
        rstn = 1'b1;
        pc = 0;
        for (int n = 0; n < 20; n++) begin
            cycle('0, '1, '0);
            pc += $countones(pulse_out);
            n_checks++;
            if ({level_out, pulse_out, evt_flag, evt_ovf} !==
                {m_level, m_pulse, m_flag, m_ovf}) begin
                n_fail++;
                $display("FAIL areset_release cyc=%0d got=%h want=%h", n,
                         {level_out, pulse_out, evt_flag, evt_ovf},
                         {m_level, m_pulse, m_flag, m_ovf});
            end
        end
        n_checks++;
        if (pc != 0) begin
            n_fail++;
            $display("FAIL areset_no_pulse got=%0d want=0", pc);
        end
    endtask

    task automatic test_random();
        logic [CH-1:0]   s = '0;
        logic [CH-1:0]   c;
        logic [2*CH-1:0] m = '1;
        for (int n = 0; n < 1000; n++) begin
            for (int k = 0; k < CH; k++) if ($urandom_range(0, 5) == 0) s[k] = ~s[k];
            if (n % 50 == 0) m = 2*CH'($urandom);
            for (int k = 0; k < CH; k++) c[k] = ($urandom_range(0, 7) == 0);
            cycle(s, m, c);
            n_checks++;
            if ({level_out, pulse_out, evt_flag, evt_ovf} !==
                {m_level, m_pulse, m_flag, m_ovf}) begin
                n_fail++;
                $display("FAIL random cyc=%0d got=%h want=%h", n,
                         {level_out, pulse_out, evt_flag, evt_ovf},
                         {m_level, m_pulse, m_flag, m_ovf});
            end
        end
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_modes();
        test_sticky();
        test_simul_clear();
        test_async_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
